// File: rtl/flit_sink.sv
// Flit sink endpoint: grants the traffic generator one send slot, then checks
// HEAD / BODY x BODY_COUNT / TAIL framing and keeps saturating statistics.
package router_pkg;
  typedef enum logic [1:0] {
    NONE_FLIT = 2'd0,
    HEAD_FLIT = 2'd1,
    BODY_FLIT = 2'd2,
    TAIL_FLIT = 2'd3
  } flit_type_t;

  typedef struct packed {
    logic        valid;
    flit_type_t  flit_type;
    logic [15:0] addr;
  } FLIT_t;

  localparam int FLIT_SIZE = $bits(FLIT_t);
endpackage

module flit_sink #(
  parameter int BODY_COUNT = 2,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_transmit,
  input  logic [router_pkg::FLIT_SIZE-1:0] i_flit,
  input  logic                           i_stall,
  output logic                           o_send,
  output logic                           o_busy,
  output logic                           o_pkt_done,
  output logic                           o_pkt_err,
  output logic [1:0]                     o_err_code,
  output logic [CNT_W-1:0]               o_pkt_count,
  output logic [CNT_W-1:0]               o_err_count,
  output logic [15:0]                    o_last_addr
);
  import router_pkg::*;

  localparam int BW = (BODY_COUNT < 1) ? 1 : $clog2(BODY_COUNT + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [BW-1:0]    BODY_LAST = BW'(BODY_COUNT);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {IDLE, GRANT, HDR, RECV, DONE, ERR, DRAIN} state_t;

  state_t        state;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic          err_to_idle;

  FLIT_t flit;
  logic  acc, is_tail, tmo;
  assign flit    = i_flit;
  assign acc     = flit.valid && (flit.flit_type != NONE_FLIT);
  assign is_tail = flit.flit_type == TAIL_FLIT;
  assign tmo     = tcnt == TMO_LAST;
  assign o_busy  = state != IDLE;

  // Framing verdict for this cycle; errors take priority over progress.
  logic       det_err, det_done, det_idle;
  logic [1:0] det_code;
  always_comb begin
    det_err  = 1'b0;
    det_done = 1'b0;
    det_idle = 1'b0;
    det_code = 2'd0;
    if (state == HDR) begin
      if (acc) begin
        if (flit.flit_type != HEAD_FLIT) begin
          det_err = 1'b1; det_code = 2'd1; det_idle = is_tail;
        end
      end else if (tmo) begin
        det_err = 1'b1; det_code = 2'd3; det_idle = 1'b1;
      end
    end else if (state == RECV) begin
      if (acc) begin
        case (flit.flit_type)
          HEAD_FLIT: begin det_err = 1'b1; det_code = 2'd1; end
          BODY_FLIT: if (bcnt == BODY_LAST) begin det_err = 1'b1; det_code = 2'd2; end
          TAIL_FLIT: begin
            if (bcnt == BODY_LAST) det_done = 1'b1;
            else begin det_err = 1'b1; det_code = 2'd2; det_idle = 1'b1; end
          end
          default: ;
        endcase
      end else if (tmo) begin
        det_err = 1'b1; det_code = 2'd3; det_idle = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bcnt        <= '0;
      tcnt        <= '0;
      err_to_idle <= 1'b0;
      o_send      <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_pkt_err   <= 1'b0;
      o_err_code  <= 2'd0;
      o_pkt_count <= '0;
      o_err_count <= '0;
      o_last_addr <= '0;
    end else begin
      o_send     <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_err  <= 1'b0;
      if (det_err) begin
        state       <= ERR;
        o_pkt_err   <= 1'b1;
        o_err_code  <= det_code;
        err_to_idle <= det_idle;
        if (o_err_count != CNT_MAX) o_err_count <= o_err_count + 1'b1;
      end else if (det_done) begin
        state      <= DONE;
        o_pkt_done <= 1'b1;
        if (o_pkt_count != CNT_MAX) o_pkt_count <= o_pkt_count + 1'b1;
      end else begin
        case (state)
          IDLE: if (i_transmit && !i_stall) begin
            state  <= GRANT;
            o_send <= 1'b1;
          end
          GRANT: begin
            state <= HDR;
            tcnt  <= '0;
          end
          HDR: if (acc) begin
            o_last_addr <= flit.addr;
            bcnt        <= '0;
            tcnt        <= '0;
            state       <= RECV;
          end else tcnt <= tcnt + 1'b1;
          RECV: if (acc) begin
            bcnt <= bcnt + 1'b1;
            tcnt <= '0;
          end else tcnt <= tcnt + 1'b1;
          DONE: state <= IDLE;
          // A TAIL arriving alongside the error pulse already closes the packet.
          ERR: begin
            tcnt  <= '0;
            state <= (err_to_idle || (acc && is_tail)) ? IDLE : DRAIN;
          end
          DRAIN: if (acc) begin
            tcnt <= '0;
            if (is_tail) state <= IDLE;
          end else if (tmo) state <= IDLE;
          else tcnt <= tcnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_flit_sink.sv
// Bench for flit_sink: directed vector table, hand sequences for stall/reset and
// saturation, then random packet streams against a stream-level framing model.
module tb_flit_sink;
  import router_pkg::*;

  localparam int BC  = 2;
  localparam int TMO = 16;
  localparam int CW  = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 i_transmit = 1'b0;
  logic                 i_stall = 1'b0;
  logic [FLIT_SIZE-1:0] i_flit = '0;
  logic                 o_send, o_busy, o_pkt_done, o_pkt_err;
  logic [1:0]           o_err_code;
  logic [CW-1:0]        o_pkt_count, o_err_count;
  logic [15:0]          o_last_addr;

  flit_sink #(.BODY_COUNT(BC), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_transmit(i_transmit), .i_flit(i_flit),
    .i_stall(i_stall), .o_send(o_send), .o_busy(o_busy), .o_pkt_done(o_pkt_done),
    .o_pkt_err(o_pkt_err), .o_err_code(o_err_code), .o_pkt_count(o_pkt_count),
    .o_err_count(o_err_count), .o_last_addr(o_last_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  int exp_code = 0;
  logic [15:0] exp_addr = '0;
  FLIT_t seq[$];

  typedef struct {
    string       name;
    string       pat;
    logic [15:0] addr;
    int          kind;   // 1 done, 2 error
    int          code;
    int          ev;
    int          ex;
    logic [15:0] eaddr;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic FLIT_t mk(input flit_type_t t, input logic v, input logic [15:0] a);
    FLIT_t f;
    f.valid = v;
    f.flit_type = t;
    f.addr = a;
    return f;
  endfunction

  function automatic bit accf(input FLIT_t f);
    return f.valid && f.flit_type != NONE_FLIT;
  endfunction

  function automatic FLIT_t at(input int k);
    if (k >= 0 && k < seq.size()) return seq[k];
    return '0;
  endfunction

  function automatic string dots(input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, "."};
    return s;
  endfunction

  // H head (addr, addr+1, ...), B body, T tail, n valid NONE, v invalid body, other idle
  task automatic load_pat(input string p, input logic [15:0] a);
    logic [15:0] ha = a;
    seq.delete();
    for (int i = 0; i < p.len(); i++) begin
      case (p[i])
        "H": begin seq.push_back(mk(HEAD_FLIT, 1'b1, ha)); ha = ha + 16'd1; end
        "B": seq.push_back(mk(BODY_FLIT, 1'b1, 16'h0)); 
        "T": seq.push_back(mk(TAIL_FLIT, 1'b1, 16'h0));
        "n": seq.push_back(mk(NONE_FLIT, 1'b1, 16'hFFFF));
        "v": seq.push_back(mk(BODY_FLIT, 1'b0, 16'h0));
        default: seq.push_back('0);
      endcase
    end
  endtask

  task automatic add_gap();
    int r = $urandom_range(0, 19);
    int len = 0;
    if (r >= 19) len = $urandom_range(14, 17);
    else if (r >= 12) len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(0, 2))
        0: seq.push_back('0);
        1: seq.push_back(mk(flit_type_t'($urandom_range(0, 3)), 1'b0, 16'($urandom)));
        default: seq.push_back(mk(NONE_FLIT, 1'b1, 16'($urandom)));
      endcase
    end
  endtask

  task automatic gen_random();
    int nb;
    seq.delete();
    add_gap();
    if ($urandom_range(0, 7) == 0) seq.push_back(mk(BODY_FLIT, 1'b1, 16'h0));
    else seq.push_back(mk(HEAD_FLIT, 1'b1, 16'($urandom)));
    nb = ($urandom_range(0, 1) == 1) ? BC : int'($urandom_range(0, 3));
    for (int i = 0; i < nb; i++) begin
      add_gap();
      if ($urandom_range(0, 11) == 0) seq.push_back(mk(HEAD_FLIT, 1'b1, 16'($urandom)));
      seq.push_back(mk(BODY_FLIT, 1'b1, 16'h0));
    end
    add_gap();
    if ($urandom_range(0, 9) != 0) seq.push_back(mk(TAIL_FLIT, 1'b1, 16'h0));
  endtask

  // Parse the flit stream (index 0 = first cycle in header wait) by the framing rules:
  // outcome, cycle of the pulse, cycle the sink is idle again, head address taken.
  task automatic predict(output int kind, output int code, output int ev, output int ex,
                         output bit upd, output logic [15:0] addr);
    int gap = 0;
    int bodies = 0;
    bit got_head = 0;
    bit to_idle = 0;
    FLIT_t f;
    kind = 0; code = 0; ev = -1; ex = -1; upd = 0; addr = '0;
    for (int k = 0; k < 400 && kind == 0; k++) begin
      f = at(k);
      if (!accf(f)) begin
        gap++;
        if (gap == TMO) begin kind = 2; code = 3; ev = k; to_idle = 1; end
      end else begin
        gap = 0;
        if (!got_head) begin
          if (f.flit_type == HEAD_FLIT) begin got_head = 1; upd = 1; addr = f.addr; end
          else begin kind = 2; code = 1; ev = k; to_idle = f.flit_type == TAIL_FLIT; end
        end else if (f.flit_type == HEAD_FLIT) begin
          kind = 2; code = 1; ev = k;
        end else if (f.flit_type == BODY_FLIT) begin
          if (bodies == BC) begin kind = 2; code = 2; ev = k; end
          else bodies++;
        end else if (bodies == BC) begin
          kind = 1; ev = k;
        end else begin
          kind = 2; code = 2; ev = k; to_idle = 1;
        end
      end
    end
    f = at(ev + 1);
    if (kind == 1 || to_idle || (accf(f) && f.flit_type == TAIL_FLIT)) ex = ev + 1;
    else begin
      gap = 0;
      for (int j = ev + 2; j < ev + 400 && ex < 0; j++) begin
        f = at(j);
        if (accf(f)) begin
          gap = 0;
          if (f.flit_type == TAIL_FLIT) ex = j;
        end else begin
          gap++;
          if (gap == TMO) ex = j;
        end
      end
    end
  endtask

  // Request, take the grant, play seq from the first header-wait cycle, watch until idle.
  task automatic run_episode(input bit hold_tx, input bit rnd_stall,
                             output int kind, output int ev, output int ex, output bit extra);
    int pulses = 0;
    kind = 0; ev = -1; ex = -1; extra = 0;
    i_stall = 1'b0;
    i_transmit = 1'b1;
    @(negedge clk);
    chk("send_latency", o_send, 1);
    i_transmit = hold_tx;
    @(negedge clk);
    if (o_send) extra = 1;
    for (int k = 0; k < 300; k++) begin
      i_flit = at(k);
      if (rnd_stall) i_stall = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (o_send) extra = 1;
      if (o_pkt_done || o_pkt_err) begin
        pulses++;
        if (pulses == 1) begin
          kind = (o_pkt_done && o_pkt_err) ? 3 : (o_pkt_done ? 1 : 2);
          ev = k;
        end
      end
      if (!o_busy) begin ex = k; break; end
    end
    if (pulses > 1) extra = 1;
    i_transmit = 1'b0;
    i_stall = 1'b0;
    i_flit = '0;
  endtask

  task automatic note_outcome(input int kind, input int code);
    if (kind == 1 && exp_pkt < (1 << CW) - 1) exp_pkt++;
    if (kind == 2) begin
      if (exp_err < (1 << CW) - 1) exp_err++;
      exp_code = code;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_send"}, o_send, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_pkt_done, 0);
    chk({tag, "_err"}, o_pkt_err, 0);
    chk({tag, "_code"}, o_err_code, 0);
    chk({tag, "_pkt_count"}, o_pkt_count, 0);
    chk({tag, "_err_count"}, o_err_count, 0);
    chk({tag, "_addr"}, o_last_addr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, ev, ex, code, pk, pc, pe, px;
    bit extra, upd;
    logic [15:0] pa;

    tbl[0] = '{"good",       "HBBT",   16'h0005, 1, 0, 3,  4,  16'h0005};
    tbl[1] = '{"short",      "HBT",    16'h0006, 2, 2, 2,  3,  16'h0006};
    tbl[2] = '{"no_head",    "BBT",    16'h0000, 2, 1, 0,  2,  16'h0006};
    tbl[3] = '{"long",       "HBBBT",  16'h0007, 2, 2, 3,  4,  16'h0007};
    tbl[4] = '{"dup_head",   "HBHBBT", 16'h0008, 2, 1, 2,  5,  16'h0008};
    tbl[5] = '{"gap15",      {"H", dots(15), "BBT"}, 16'h0015, 1, 1, 18, 19, 16'h0015};
    tbl[6] = '{"gap16",      {"H", dots(16)},        16'h0016, 2, 3, 16, 17, 16'h0016};
    tbl[7] = '{"ignored",    "HvBnBT", 16'h0A0A, 1, 3, 5,  6,  16'h0A0A};
    tbl[8] = '{"hdr_tmo",    "",       16'h0000, 2, 3, 15, 16, 16'h0A0A};
    tbl[9] = '{"tail_first", "T",      16'h0000, 2, 1, 0,  1,  16'h0A0A};

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      load_pat(tbl[i].pat, tbl[i].addr);
      run_episode(1'b0, 1'b0, kind, ev, ex, extra);
      chk({tbl[i].name, "_kind"}, kind, tbl[i].kind);
      chk({tbl[i].name, "_event_cycle"}, ev, tbl[i].ev);
      chk({tbl[i].name, "_idle_cycle"}, ex, tbl[i].ex);
      chk({tbl[i].name, "_extra_pulse"}, extra, 0);
      chk({tbl[i].name, "_code"}, o_err_code, tbl[i].code);
      chk({tbl[i].name, "_addr"}, o_last_addr, tbl[i].eaddr);
      note_outcome(tbl[i].kind, tbl[i].code);
    end
    chk("tbl_pkt_count", o_pkt_count, 3);
    chk("tbl_err_count", o_err_count, 7);

    // back-pressure holds off the grant, then reset lands mid-packet
    i_stall = 1'b1;
    i_transmit = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_no_send", o_send, 0);
      chk("stall_idle", o_busy, 0);
    end
    i_stall = 1'b0;
    @(negedge clk);
    chk("unstall_send", o_send, 1);
    i_transmit = 1'b0;
    @(negedge clk);
    i_flit = mk(HEAD_FLIT, 1'b1, 16'h1234);
    @(negedge clk);
    i_flit = mk(BODY_FLIT, 1'b1, 16'h0);
    @(negedge clk);
    chk("recv_busy", o_busy, 1);
    chk("recv_addr", o_last_addr, 16'h1234);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    i_flit = mk(TAIL_FLIT, 1'b1, 16'h0);
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_err", o_pkt_err, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_no_err", o_pkt_err, 0);
    chk("post_reset_idle", o_busy, 0);
    i_flit = '0;
    exp_pkt = 0; exp_err = 0; exp_code = 0; exp_addr = '0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      load_pat("HBBT", 16'h0100 + 16'(i));
      run_episode(1'b1, 1'b0, kind, ev, ex, extra);
      chk("sat_kind", kind, 1);
      note_outcome(kind, 0);
    end
    exp_addr = 16'h0110;
    chk("sat_pkt_count", o_pkt_count, 15);
    chk("sat_addr", o_last_addr, exp_addr);

    for (int n = 0; n < 40; n++) begin
      gen_random();
      predict(pk, pc, pe, px, upd, pa);
      run_episode($urandom_range(0, 1) == 1, 1'b1, kind, ev, ex, extra);
      chk("rnd_kind", kind, pk);
      chk("rnd_event_cycle", ev, pe);
      chk("rnd_idle_cycle", ex, px);
      chk("rnd_extra_pulse", extra, 0);
      note_outcome(pk, pc);
      if (upd) exp_addr = pa;
      chk("rnd_code", o_err_code, exp_code);
      chk("rnd_pkt_count", o_pkt_count, exp_pkt);
      chk("rnd_err_count", o_err_count, exp_err);
      chk("rnd_addr", o_last_addr, exp_addr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
